// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite single-port SRAM slave: byte/halfword/word access and a two-cycle ERROR response.
// Define AHB3LITE_SRAM_WAIT_STATE_EN to stall every OKAY transfer for WAIT_STATES cycles.
//
// state  | meaning
// IDLE   | ready, OKAY; a pending data phase completes here
// WAIT   | inserting wait states (HREADYOUT = 0)
// ERR1   | first ERROR cycle (HREADYOUT = 0, HRESP = 1)
// ERR2   | second ERROR cycle (HREADYOUT = 1, HRESP = 1)
module ahb3lite_sram_slave #(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic [HDATA_SIZE-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

`ifdef AHB3LITE_SRAM_WAIT_STATE_EN
    localparam state_t OK_NEXT = ST_WAIT;
`else
    localparam state_t OK_NEXT = ST_IDLE;
`endif

    state_t            state_q, state_d;
    logic              accept, take, addr_err, commit;
    logic              pend_q, write_q;
    logic [1:0]        size_q;
    logic [AW+1:0]     addr_q;
    logic [AW-1:0]     widx;
    logic [3:0]        be;
    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];
    logic              unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HTRANS[0], 4'(WAIT_STATES)};

    assign accept = HSEL & HREADY & HTRANS[1];
    assign take   = accept & HREADYOUT;

    always_comb begin
        addr_err = 1'b0;
        if (HSIZE > 3'd2)
            addr_err = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])
            addr_err = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
            addr_err = 1'b1;
        if (HADDR >= HADDR_SIZE'(MEM_DEPTH * 4))
            addr_err = 1'b1;
    end

`ifdef AHB3LITE_SRAM_WAIT_STATE_EN
    logic [3:0] cnt_q;

    // Loaded with WAIT_STATES-1 so the WAIT state lasts exactly WAIT_STATES cycles.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            cnt_q <= 4'd0;
        else if (take && !addr_err)
            cnt_q <= 4'(WAIT_STATES - 1);
        else if (state_q == ST_WAIT && cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
    end
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept)
                    state_d = addr_err ? ST_ERR1 : OK_NEXT;
                else
                    state_d = ST_IDLE;
            end
`ifdef AHB3LITE_SRAM_WAIT_STATE_EN
            ST_WAIT: begin
                if (cnt_q == 4'd0)
                    state_d = ST_IDLE;
            end
`endif
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from the state register only, so HREADY fed back from HREADYOUT forms no loop.
    assign HREADYOUT = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
        end else if (HREADYOUT) begin
            pend_q <= take & ~addr_err;
            if (take) begin
                addr_q  <= HADDR[AW+1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE[1:0];
            end
        end
    end

    assign widx   = addr_q[AW+1:2];
    assign commit = pend_q & write_q & (state_q == ST_IDLE);

    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be = 4'b0001 << addr_q[1:0];
            2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k])
                    mem[widx][8*k +: 8] <= HWDATA[8*k +: 8];
            end
        end
    end

    assign HRDATA = (pend_q && !write_q && state_q == ST_IDLE) ? mem[widx] : '0;

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Self-checking bench for ahb3lite_sram_slave: directed vector table, pipelined corner cases,
// and randomized transfers against a byte-array reference model.
module tb_ahb3lite_sram_slave;

    localparam int MEM_DEPTH = 256;
    localparam int WS        = 2;
`ifdef AHB3LITE_SRAM_WAIT_STATE_EN
    localparam int WS_EXP = WS;
`else
    localparam int WS_EXP = 0;
`endif

    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    assign HREADY = HREADYOUT;

    ahb3lite_sram_slave #(
        .HADDR_SIZE (32),
        .HDATA_SIZE (32),
        .MEM_DEPTH  (MEM_DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HTRANS   (HTRANS),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] mem_b [MEM_DEPTH*4];

    typedef struct {
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b1;
        if ((a % (32'd1 << sz)) != 32'd0) return 1'b1;
        if (a >= 32'(MEM_DEPTH * 4)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_write(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int b = 0; b < (1 << sz); b++) begin
            int lane;
            logic [9:0] idx;
            lane = int'(a[1:0]) + b;
            idx  = 10'(a + 32'(b));
            mem_b[idx] = wd[8*lane +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [9:0] base;
        base = {a[9:2], 2'b00};
        return {mem_b[base + 10'd3], mem_b[base + 10'd2], mem_b[base + 10'd1], mem_b[base]};
    endfunction

    // Called just after an edge; returns just after the edge that completes the data phase.
    task automatic wait_ready(input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                              output int waits, output logic low_resp, output logic ok);
        int c;
        ok = 1'b0; waits = 0; low_resp = 1'b0; rd = '0; rsp = 1'b0; c = 0;
        HWDATA = $urandom();
        while (!ok && c < 40) begin
            @(negedge HCLK);
            if (HREADYOUT) begin
                rd = HRDATA;
                rsp = HRESP;
                HWDATA = wd;
                ok = 1'b1;
            end else begin
                waits++;
                low_resp = low_resp | HRESP;
            end
            @(posedge HCLK); #1;
            c++;
        end
    endtask

    task automatic run_check(input string tag, input logic wr, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic rsp, lowr, ok;
        int waits;
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = a; HWRITE = wr; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0;
        wait_ready(wd, rd, rsp, waits, lowr, ok);
        check($sformatf("%s done", tag), 32'(ok), 32'd1);
        check($sformatf("%s hrdata", tag), rd, exp_rd);
        check($sformatf("%s hresp", tag), 32'(rsp), 32'(exp_err));
        check($sformatf("%s waits", tag), 32'(waits), exp_err ? 32'd1 : 32'(WS_EXP));
        check($sformatf("%s stall_resp", tag), 32'(lowr), 32'(exp_err));
        if (wr && !exp_err)
            model_write(sz, a, wd);
    endtask

    initial begin
        logic [31:0] rd, a, wd, erd;
        logic rsp, lowr, ok, wr, eerr;
        logic [2:0] sz;
        int waits;

        vecs[0]  = '{1'b1, 3'd2, 32'h004, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 3'd2, 32'h004, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'd2, 32'h008, 32'h00000000, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 3'd0, 32'h009, 32'h0000AA00, 32'h0, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 32'h00A, 32'h12340000, 32'h0, 1'b0};
        vecs[5]  = '{1'b0, 3'd2, 32'h008, 32'h0, 32'h1234AA00, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 32'h002, 32'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 3'd2, 32'h400, 32'hFFFFFFFF, 32'h0, 1'b1};
        vecs[8]  = '{1'b0, 3'd2, 32'h004, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 3'd2, 32'h000, 32'h0, init_word(0), 1'b0};
        vecs[10] = '{1'b0, 3'd0, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{1'b1, 3'd1, 32'h003, 32'hFFFFFFFF, 32'h0, 1'b1};
        vecs[12] = '{1'b0, 3'd3, 32'h000, 32'h0, 32'h0, 1'b1};
        vecs[13] = '{1'b0, 3'd2, 32'h3FC, 32'h0, init_word(255), 1'b0};
        vecs[14] = '{1'b1, 3'd0, 32'h3FF, 32'h77000000, 32'h0, 1'b0};
        vecs[15] = '{1'b0, 3'd2, 32'h3FC, 32'h0, (init_word(255) & 32'h00FFFFFF) | 32'h77000000, 1'b0};
        vecs[16] = '{1'b0, 3'd2, 32'h000, 32'h0, init_word(0), 1'b0};

        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'd0; HADDR = '0; HWDATA = '0;
        HWRITE = 1'b0; HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        check("reset hreadyout", 32'(HREADYOUT), 32'd1);
        check("reset hresp", 32'(HRESP), 32'd0);
        check("reset hrdata", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        for (int i = 0; i < MEM_DEPTH; i++)
            run_check($sformatf("init%0d", i), 1'b1, 3'd2, 32'(i * 4), init_word(i), 32'h0, 1'b0);

        // Reset during the data phase of a write to 0x10.
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0; HWDATA = 32'hBAADF00D;
        @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        check("rst_mid hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_mid hresp", 32'(HRESP), 32'd0);
        check("rst_mid hrdata", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        run_check("rst_mid read", 1'b0, 3'd2, 32'h10, 32'h0, init_word(4), 1'b0);

        for (int i = 0; i < 17; i++)
            run_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].addr,
                      vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err);

        // Write immediately followed by a read of the same word.
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWRITE = 1'b0;
        wait_ready(32'h55, rd, rsp, waits, lowr, ok);
        check("b2b wr done", 32'(ok), 32'd1);
        check("b2b wr hresp", 32'(rsp), 32'd0);
        check("b2b wr waits", 32'(waits), 32'(WS_EXP));
        HSEL = 1'b0; HTRANS = 2'd0;
        wait_ready(32'h0, rd, rsp, waits, lowr, ok);
        check("b2b rd done", 32'(ok), 32'd1);
        check("b2b rd hrdata", rd, 32'h00000055);
        check("b2b rd waits", 32'(waits), 32'(WS_EXP));
        model_write(3'd2, 32'h20, 32'h55);

        // Error, then a new transfer issued during ERR2.
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h2; HWRITE = 1'b0; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0;
        @(negedge HCLK);
        check("err1 hreadyout", 32'(HREADYOUT), 32'd0);
        check("err1 hresp", 32'(HRESP), 32'd1);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h4; HWRITE = 1'b0; HSIZE = 3'd2;
        @(negedge HCLK);
        check("err2 hreadyout", 32'(HREADYOUT), 32'd1);
        check("err2 hresp", 32'(HRESP), 32'd1);
        check("err2 hrdata", HRDATA, 32'd0);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0;
        wait_ready(32'h0, rd, rsp, waits, lowr, ok);
        check("err2 next done", 32'(ok), 32'd1);
        check("err2 next hrdata", rd, model_read(32'h4));
        check("err2 next hresp", 32'(rsp), 32'd0);
        check("err2 next waits", 32'(waits), 32'(WS_EXP));

        for (int i = 0; i < 300; i++) begin
            int r;
            wr = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            r = int'($urandom_range(0, 19));
            if (r == 0)
                a = 32'(MEM_DEPTH * 4) + 32'($urandom_range(0, 255));
            else if (r == 1)
                a = $urandom() | 32'h80000000;
            else begin
                a = 32'($urandom_range(0, MEM_DEPTH * 4 - 1));
                if ($urandom_range(0, 3) != 0 && sz <= 3'd2)
                    a = a & ~((32'd1 << sz) - 32'd1);
            end
            wd = $urandom();
            eerr = model_err(sz, a);
            erd = (!eerr && !wr) ? model_read(a) : 32'h0;
            run_check($sformatf("rnd%0d", i), wr, sz, a, wd, erd, eerr);
            repeat ($urandom_range(0, 1)) begin
                @(posedge HCLK); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
